// File: rtl/hamming_secded_dec_pipe.sv
// Two-stage pipelined Hamming decoder with optional SECDED overall parity,
// valid/ready handshake and saturating corrected/uncorrectable word counters.
module hamming_secded_dec_pipe #(
    parameter int DATA_W = 6,
    parameter int PAR_W  = 4,
    parameter int SECDED = 0,
    parameter int CNT_W  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cnt_clr,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W+PAR_W+SECDED-1:0]  in_code,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_err_corr,
    output logic                            out_err_uncorr,
    output logic [PAR_W-1:0]                out_syndrome,
    output logic [CNT_W-1:0]                cnt_corr,
    output logic [CNT_W-1:0]                cnt_uncorr
);

    localparam int CODE_W = DATA_W + PAR_W + SECDED;
    localparam int N_POS  = DATA_W + PAR_W;

    if ((1 << PAR_W) < N_POS + 1) begin : g_param_check
        $error("PAR_W too small for DATA_W: need 2**PAR_W >= DATA_W+PAR_W+1");
    end

    // Hamming position of data bit idx: the idx-th non-power-of-two position.
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int p = 1; p <= N_POS; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == idx) pos = p;
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic logic [PAR_W-1:0] calc_syndrome(input logic [DATA_W-1:0] data,
                                                        input logic [PAR_W-1:0]  parity);
        logic [PAR_W-1:0] syn;
        int               pos;
        syn = parity;
        for (int i = 0; i < DATA_W; i++) begin
            pos = data_pos(i);
            for (int k = 0; k < PAR_W; k++) begin
                if (pos[k]) syn[k] = syn[k] ^ data[i];
            end
        end
        return syn;
    endfunction

    logic [DATA_W-1:0] raw_data;
    logic [PAR_W-1:0]  raw_par;
    logic [PAR_W-1:0]  syn_c;
    logic              ovr_c;

    logic              s1_valid;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_ovr;
    logic [DATA_W-1:0] s1_data;

    logic [DATA_W-1:0] fix_data;
    logic              fix_corr;
    logic              fix_uncorr;

    logic              stall;
    logic              xfer;

    assign raw_data = in_code[DATA_W-1:0];
    assign raw_par  = in_code[DATA_W +: PAR_W];
    assign syn_c    = calc_syndrome(raw_data, raw_par);
    // Without SECDED every nonzero syndrome is treated as a single-bit error.
    assign ovr_c    = (SECDED != 0) ? (^in_code) : 1'b1;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign xfer     = out_valid & out_ready;

    always_comb begin
        fix_data   = s1_data;
        fix_corr   = 1'b0;
        fix_uncorr = 1'b0;
        if (s1_syn == '0) begin
            fix_corr = (SECDED != 0) && s1_ovr;
        end else if (!s1_ovr) begin
            fix_uncorr = 1'b1;
        end else if (int'(s1_syn) <= N_POS) begin
            // A syndrome pointing at a parity position leaves the data untouched.
            fix_corr = 1'b1;
            for (int i = 0; i < DATA_W; i++) begin
                if (data_pos(i) == int'(s1_syn)) fix_data[i] = ~fix_data[i];
            end
        end else begin
            fix_uncorr = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid       <= 1'b0;
            s1_syn         <= '0;
            s1_ovr         <= 1'b0;
            s1_data        <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_err_corr   <= 1'b0;
            out_err_uncorr <= 1'b0;
            out_syndrome   <= '0;
        end else if (!stall) begin
            s1_valid       <= in_valid;
            s1_syn         <= syn_c;
            s1_ovr         <= ovr_c;
            s1_data        <= raw_data;
            out_valid      <= s1_valid;
            out_data       <= fix_data;
            out_err_corr   <= fix_corr;
            out_err_uncorr <= fix_uncorr;
            out_syndrome   <= s1_syn;
        end
    end

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (cnt_clr) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else begin
            if (xfer && out_err_corr && (cnt_corr != '1))
                cnt_corr <= cnt_corr + CNT_W'(1);
            if (xfer && out_err_uncorr && (cnt_uncorr != '1))
                cnt_uncorr <= cnt_uncorr + CNT_W'(1);
        end
    end

endmodule
